instr_fetch_unit: RTL and testbench

//  Fetch stage of the MIPS core. Owns the PC and sequences instruction-memory reads with a req/ack handshake.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/pc_next_sel.sv | 28 ++
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode constants, fetch FSM encoding, the fetch NOP and
// branch-offset helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, decode valid/ready and redirect inputs.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        ex_jump;
  logic        ex_branch;
  logic        ex_zero;
  logic [31:0] ex_pc_plus4;
  logic [15:0] ex_imm;
  logic [25:0] ex_jidx;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc_plus4,
    input  imem_ack, imem_rdata, if_ready,
    input  ex_jump, ex_branch, ex_zero, ex_pc_plus4, ex_imm, ex_jidx
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc_plus4,
    output imem_ack, imem_rdata, if_ready,
    output ex_jump, ex_branch, ex_zero, ex_pc_plus4, ex_imm, ex_jidx
  );
endinterface

// File: rtl/pc_next_sel.sv
// Redirect detection and target selection (jump over taken branch) plus the sequential pc+4.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [31:0] fetch_pc,
  input  logic        ex_jump,
  input  logic        ex_branch,
  input  logic        ex_zero,
  input  logic [31:0] ex_pc_plus4,
  input  logic [15:0] ex_imm,
  input  logic [25:0] ex_jidx,
  output logic        redir,
  output logic [31:0] target,
  output logic [31:0] pc_plus4
);

  logic [31:0] jtgt;
  logic [31:0] btgt;

  always_comb begin
    jtgt     = {ex_pc_plus4[31:28], ex_jidx, 2'b00};
    btgt     = ex_pc_plus4 + branch_offset(ex_imm);
    redir    = ex_jump | (ex_branch & ex_zero);
    target   = ex_jump ? jtgt : btgt;
    pc_plus4 = fetch_pc + 32'd4;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: owns the PC, runs one imem request at a time, buffers into an output
// register plus one skid entry, and squashes wrong-path work on jump/branch redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);

  mips_pkg::fetch_state_e state_q, state_d;
  logic        active_q;
  logic        kill_q, kill_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  logic [31:0] fetch_pc;
  logic        redir;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // addr_q freezes the in-flight address so a redirect during S_WAIT only moves pc_q
  assign fetch_pc = (state_q == mips_pkg::S_WAIT) ? addr_q : pc_q;

  pc_next_sel u_pc_next_sel (
    .fetch_pc    (fetch_pc),
    .ex_jump     (bus.ex_jump),
    .ex_branch   (bus.ex_branch),
    .ex_zero     (bus.ex_zero),
    .ex_pc_plus4 (bus.ex_pc_plus4),
    .ex_imm      (bus.ex_imm),
    .ex_jidx     (bus.ex_jidx),
    .redir       (redir),
    .target      (target),
    .pc_plus4    (pc_plus4)
  );

  // active_q keeps req low during reset; a redirect in S_IDLE suppresses the stale request
  assign bus.imem_req    = active_q & ((state_q == mips_pkg::S_WAIT) |
                                       ((state_q == mips_pkg::S_IDLE) & ~redir));
  assign bus.imem_addr   = fetch_pc;
  assign bus.if_valid    = valid_q;
  assign bus.if_instr    = valid_q ? instr_q : NOP_INSTR;
  assign bus.if_pc_plus4 = pc4_q;

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;

    if (valid_q && bus.if_ready) valid_d = 1'b0;

    unique case (state_q)
      mips_pkg::S_IDLE: begin
        if (active_q && !redir) begin
          addr_d  = pc_q;
          state_d = mips_pkg::S_WAIT;
        end
      end
      mips_pkg::S_WAIT: begin
        if (bus.imem_ack) begin
          if (kill_q || redir) begin
            kill_d  = 1'b0;
            state_d = mips_pkg::S_IDLE;
          end else if (!valid_q || bus.if_ready) begin
            instr_d = bus.imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            state_d = mips_pkg::S_IDLE;
          end else begin
            skid_instr_d = bus.imem_rdata;
            skid_pc4_d   = pc_plus4;
            pc_d         = pc_plus4;
            state_d      = mips_pkg::S_HOLD;
          end
        end else if (redir) begin
          kill_d = 1'b1;
        end
      end
      mips_pkg::S_HOLD: begin
        if (bus.if_ready) begin
          instr_d = skid_instr_q;
          pc4_d   = skid_pc4_q;
          valid_d = 1'b1;
          state_d = mips_pkg::S_IDLE;
        end
      end
      default: state_d = mips_pkg::S_IDLE;
    endcase

    // Redirect overrides everything above: output squashed, skid dropped
    if (redir) begin
      pc_d    = target;
      valid_d = 1'b0;
      if (state_q == mips_pkg::S_HOLD) state_d = mips_pkg::S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= mips_pkg::S_IDLE;
      active_q     <= 1'b0;
      kill_q       <= 1'b0;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc4_q        <= 32'h0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      active_q     <= 1'b1;
      kill_q       <= kill_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: latency-configurable imem model, expected-instruction scoreboard
// filled at request time and drained on each decode handshake.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic clk;
  logic rst_n;
  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  exp_t        sb[$];
  logic [31:0] exp_addr;
  logic        pending;
  int unsigned cnt;
  logic [31:0] pend_addr;
  int unsigned lat;
  logic        rand_lat;
  logic        redir_now;
  logic [31:0] redir_tgt;
  int unsigned xfer_cnt;
  int unsigned req_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mips_pkg::OP_LW, a[27:2]};
  endfunction

  // One clock of bench activity, evaluated mid-cycle; returns just after the next rising edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      pending      = 1'b0;
      bus.imem_ack = 1'b0;
    end else begin
      bus.imem_ack = 1'b0;
      if (pending) begin
        check_eq("req_held", {31'd0, bus.imem_req}, 32'd1);
        check_eq("addr_stable", bus.imem_addr, pend_addr);
        cnt--;
        if (cnt == 0) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(pend_addr);
          pending        = 1'b0;
        end
      end else if (bus.imem_req) begin
        check_eq("req_addr", bus.imem_addr, exp_addr);
        sb.push_back('{instr: mem_word(exp_addr), pc4: exp_addr + 32'd4});
        pend_addr = bus.imem_addr;
        cnt       = rand_lat ? $urandom_range(1, 3) : lat;
        pending   = 1'b1;
        exp_addr  = exp_addr + 32'd4;
        req_cnt++;
      end
      if (bus.if_valid && bus.if_ready && !redir_now) begin
        if (sb.size() == 0) begin
          check_eq("xfer_unexpected", bus.if_instr, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          check_eq("if_instr", bus.if_instr, e.instr);
          check_eq("if_pc_plus4", bus.if_pc_plus4, e.pc4);
        end
        xfer_cnt++;
      end
      if (redir_now) begin
        sb.delete();
        exp_addr = redir_tgt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int unsigned n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_ex();
    bus.ex_jump     = 1'b0;
    bus.ex_branch   = 1'b0;
    bus.ex_zero     = 1'b0;
    bus.ex_pc_plus4 = 32'h0;
    bus.ex_imm      = 16'h0;
    bus.ex_jidx     = 26'h0;
    redir_now       = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    pending  = 1'b0;
    sb.delete();
    exp_addr = 32'h0;
    run(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_pending(input string tag);
    int unsigned k;
    k = 0;
    while (!pending && k < 20) begin
      tick();
      k++;
    end
    check_eq(tag, {31'd0, pending}, 32'd1);
  endtask

  int unsigned     x0;
  logic [31:0] held;

  initial begin
    rst_n          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.if_ready   = 1'b1;
    clear_ex();
    lat      = 1;
    rand_lat = 1'b0;
    pending  = 1'b0;
    exp_addr = 32'h0;
    xfer_cnt = 0;
    req_cnt  = 0;
    #2;
    check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.if_valid}, 32'd0);
    check_eq("rst_instr", bus.if_instr, 32'h0);
    check_eq("rst_pc4", bus.if_pc_plus4, 32'h0);

    // 1: sequential fetch from reset, 1-cycle latency
    do_reset();
    run(10);
    check_eq("t1_reqs", {31'd0, req_cnt >= 3}, 32'd1);
    check_eq("t1_xfers", {31'd0, xfer_cnt >= 3}, 32'd1);

    // 2: decode stall fills output and skid, then drains in order
    bus.if_ready = 1'b0;
    run(8);
    check_eq("t2_state", 32'(dut.state_q), 32'(mips_pkg::S_HOLD));
    held = bus.if_instr;
    check_eq("t2_front", held, sb[0].instr);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t2_stable", bus.if_instr, held);
      check_eq("t2_noreq", {31'd0, bus.imem_req}, 32'd0);
      check_eq("t2_hold", 32'(dut.state_q), 32'(mips_pkg::S_HOLD));
    end
    x0 = xfer_cnt;
    bus.if_ready = 1'b1;
    run(6);
    check_eq("t2_drain", {31'd0, xfer_cnt >= x0 + 2}, 32'd1);

    // 3: jump redirect
    bus.ex_jump = 1'b1;
    bus.ex_pc_plus4 = 32'h0040_0010;
    bus.ex_jidx = 26'h10;
    redir_now = 1'b1;
    redir_tgt = 32'h0000_0040;
    tick();
    check_eq("t3_squash", {31'd0, bus.if_valid}, 32'd0);
    clear_ex();
    x0 = xfer_cnt;
    run(8);
    check_eq("t3_xfers", {31'd0, xfer_cnt > x0}, 32'd1);

    // 4: taken beq, then not-taken beq stays sequential
    bus.ex_branch = 1'b1;
    bus.ex_zero = 1'b1;
    bus.ex_pc_plus4 = 32'h0000_0100;
    bus.ex_imm = 16'hFFFE;
    redir_now = 1'b1;
    redir_tgt = 32'h0000_00F8;
    tick();
    check_eq("t4_squash", {31'd0, bus.if_valid}, 32'd0);
    clear_ex();
    run(6);
    bus.ex_branch = 1'b1;
    bus.ex_pc_plus4 = 32'h0000_0100;
    bus.ex_imm = 16'hFFFE;
    tick();
    clear_ex();
    x0 = xfer_cnt;
    run(8);
    check_eq("t4_xfers", {31'd0, xfer_cnt > x0}, 32'd1);

    // 5: redirect while a 3-cycle read is in flight
    lat = 3;
    wait_pending("t5_inflight");
    bus.ex_jump = 1'b1;
    bus.ex_pc_plus4 = 32'h0040_0010;
    bus.ex_jidx = 26'h20;
    redir_now = 1'b1;
    redir_tgt = 32'h0000_0080;
    tick();
    clear_ex();
    x0 = xfer_cnt;
    run(20);
    check_eq("t5_xfers", {31'd0, xfer_cnt > x0}, 32'd1);

    // Random decode stalls and memory latency
    rand_lat = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus.if_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    bus.if_ready = 1'b1;
    rand_lat = 1'b0;

    // 6: asynchronous reset in the middle of a request
    wait_pending("t6_inflight");
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t6_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("t6_valid", {31'd0, bus.if_valid}, 32'd0);
    check_eq("t6_instr", bus.if_instr, 32'h0);
    pending = 1'b0;
    sb.delete();
    exp_addr = 32'h0;
    run(2);
    rst_n = 1'b1;
    lat = 1;
    x0 = xfer_cnt;
    run(10);
    check_eq("t6_refetch", {31'd0, xfer_cnt >= x0 + 3}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
